// File: rtl/dice_light_pkg.sv
// Shared constants for the dice / traffic-light result monitor.
// Light codes, error causes, light FSM states and dice range.
package dice_light_pkg;

    // Lamp codes, bit order {red, amber, green}
    localparam logic [2:0] LC_RED       = 3'b100;
    localparam logic [2:0] LC_RED_AMBER = 3'b110;
    localparam logic [2:0] LC_GREEN     = 3'b001;
    localparam logic [2:0] LC_AMBER     = 3'b010;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_DICE_ILL  = 2'd1;
    localparam logic [1:0] ERR_LIGHT_ILL = 2'd2;
    localparam logic [1:0] ERR_LIGHT_SEQ = 2'd3;

    localparam logic [2:0] DICE_MIN = 3'd1;
    localparam logic [2:0] DICE_MAX = 3'd6;

    typedef enum logic [2:0] {
        ST_UNSYNC,
        ST_RED,
        ST_RED_AMBER,
        ST_GREEN,
        ST_AMBER
    } light_st_e;

    function automatic logic is_dice_legal(input logic [2:0] v);
        return (v >= DICE_MIN) && (v <= DICE_MAX);
    endfunction

endpackage

// File: rtl/light_seq_checker.sv
// Traffic-light sequence checker: light FSM, illegal/sequence detection, lamps.
// Ports: clk, rst (sync, active-low), i_valid, i_force_unsync, i_code -> lamps, o_ill, o_seq.
module light_seq_checker
    import dice_light_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_valid,
    input  logic       i_force_unsync,
    input  logic [2:0] i_code,
    output logic       o_red,
    output logic       o_amber,
    output logic       o_green,
    output logic       o_ill,
    output logic       o_seq
);

    light_st_e  r_st;
    logic [2:0] r_lamps;

    light_st_e  w_st_eff;
    light_st_e  w_obs;
    light_st_e  w_succ;
    logic       w_legal;

    // A mode change drops sync before this sample is judged
    always_comb begin
        w_st_eff = i_force_unsync ? ST_UNSYNC : r_st;
    end

    always_comb begin
        w_legal = 1'b1;
        w_obs   = ST_UNSYNC;
        case (i_code)
            LC_RED:       w_obs = ST_RED;
            LC_RED_AMBER: w_obs = ST_RED_AMBER;
            LC_GREEN:     w_obs = ST_GREEN;
            LC_AMBER:     w_obs = ST_AMBER;
            default:      w_legal = 1'b0;
        endcase
    end

    always_comb begin
        case (w_st_eff)
            ST_RED:       w_succ = ST_RED_AMBER;
            ST_RED_AMBER: w_succ = ST_GREEN;
            ST_GREEN:     w_succ = ST_AMBER;
            ST_AMBER:     w_succ = ST_RED;
            default:      w_succ = ST_UNSYNC;
        endcase
    end

    always_comb begin
        o_ill = i_valid && !w_legal;
        o_seq = i_valid && w_legal
             && (w_st_eff != ST_UNSYNC)
             && (w_obs != w_st_eff)
             && (w_obs != w_succ);
    end

    // Legal codes always load, so a sequence error resyncs to the observed state
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_st    <= ST_UNSYNC;
            r_lamps <= 3'b000;
        end else if (i_valid) begin
            if (w_legal) begin
                r_st    <= w_obs;
                r_lamps <= i_code;
            end else begin
                r_st    <= w_st_eff;
            end
        end else if (i_force_unsync) begin
            r_st <= ST_UNSYNC;
        end
    end

    assign o_red   = r_lamps[2];
    assign o_amber = r_lamps[1];
    assign o_green = r_lamps[0];

endmodule

// File: rtl/dice_light_monitor.sv
// Receive-side checker for the dice / traffic-light generator result bus.
// Ports: clk, rst (sync, active-low), sel, result, sample, clr_err ->
//   dice_val, red/amber/green, err_flag, err_pulse, err_code, sample_cnt, err_cnt.
module dice_light_monitor
    import dice_light_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel,
    input  logic [2:0]       result,
    input  logic             sample,
    input  logic             clr_err,
    output logic [2:0]       dice_val,
    output logic             red,
    output logic             amber,
    output logic             green,
    output logic             err_flag,
    output logic             err_pulse,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             r_last_mode;
    logic [2:0]       r_dice_val;
    logic             r_err_flag;
    logic             r_err_pulse;
    logic [1:0]       r_err_code;
    logic [CNT_W-1:0] r_sample_cnt;
    logic [CNT_W-1:0] r_err_cnt;

    logic             w_mode_chg;
    logic             w_light_vld;
    logic             w_dice_vld;
    logic             w_dice_ill;
    logic             w_light_ill;
    logic             w_light_seq;
    logic             w_err;
    logic [1:0]       w_code;

    always_comb begin
        w_mode_chg  = sample && (sel != r_last_mode);
        w_light_vld = sample && sel;
        w_dice_vld  = sample && !sel;
        w_dice_ill  = w_dice_vld && !is_dice_legal(result);
        w_err       = w_dice_ill || w_light_ill || w_light_seq;
        w_code      = ERR_LIGHT_SEQ;
        if (w_dice_ill) begin
            w_code = ERR_DICE_ILL;
        end else if (w_light_ill) begin
            w_code = ERR_LIGHT_ILL;
        end
    end

    light_seq_checker u_light (
        .clk            (clk),
        .rst            (rst),
        .i_valid        (w_light_vld),
        .i_force_unsync (w_mode_chg),
        .i_code         (result),
        .o_red          (red),
        .o_amber        (amber),
        .o_green        (green),
        .o_ill          (w_light_ill),
        .o_seq          (w_light_seq)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last_mode  <= 1'b0;
            r_dice_val   <= 3'd0;
            r_err_flag   <= 1'b0;
            r_err_pulse  <= 1'b0;
            r_err_code   <= ERR_NONE;
            r_sample_cnt <= '0;
            r_err_cnt    <= '0;
        end else begin
            r_err_pulse <= w_err;
            if (sample) begin
                r_last_mode <= sel;
                if (r_sample_cnt != CNT_MAX) begin
                    r_sample_cnt <= r_sample_cnt + CNT_ONE;
                end
            end
            if (w_dice_vld && !w_dice_ill) begin
                r_dice_val <= result;
            end
            // An error on the same edge as clr_err keeps the flag set
            if (w_err) begin
                r_err_flag <= 1'b1;
                r_err_code <= w_code;
                if (r_err_cnt != CNT_MAX) begin
                    r_err_cnt <= r_err_cnt + CNT_ONE;
                end
            end else if (clr_err) begin
                r_err_flag <= 1'b0;
            end
        end
    end

    assign dice_val   = r_dice_val;
    assign err_flag   = r_err_flag;
    assign err_pulse  = r_err_pulse;
    assign err_code   = r_err_code;
    assign sample_cnt = r_sample_cnt;
    assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_dice_light_monitor.sv
// Bench for dice_light_monitor: directed table plus random run against a model.
// A second instance with CNT_W=3 shares the inputs to exercise saturation.
module tb_dice_light_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sel = 1'b0;
    logic [2:0] result = 3'd0;
    logic       sample = 1'b0;
    logic       clr_err = 1'b0;

    logic [2:0] dice_val;
    logic       red, amber, green;
    logic       err_flag, err_pulse;
    logic [1:0] err_code;
    logic [7:0] sample_cnt, err_cnt;

    logic [2:0] s_dice_val;
    logic       s_red, s_amber, s_green;
    logic       s_err_flag, s_err_pulse;
    logic [1:0] s_err_code;
    logic [2:0] s_sample_cnt, s_err_cnt;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    dice_light_monitor #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .sel(sel), .result(result),
        .sample(sample), .clr_err(clr_err),
        .dice_val(dice_val), .red(red), .amber(amber), .green(green),
        .err_flag(err_flag), .err_pulse(err_pulse), .err_code(err_code),
        .sample_cnt(sample_cnt), .err_cnt(err_cnt)
    );

    dice_light_monitor #(.CNT_W(3)) dut_s (
        .clk(clk), .rst(rst), .sel(sel), .result(result),
        .sample(sample), .clr_err(clr_err),
        .dice_val(s_dice_val), .red(s_red), .amber(s_amber), .green(s_green),
        .err_flag(s_err_flag), .err_pulse(s_err_pulse), .err_code(s_err_code),
        .sample_cnt(s_sample_cnt), .err_cnt(s_err_cnt)
    );

    // Reference model: light cycle kept as a position in an ordered list
    logic [2:0] lc [4] = '{3'b100, 3'b110, 3'b001, 3'b010};
    int         m_pos;
    int         m_last;
    int         m_dice, m_lamps, m_pulse, m_flag, m_code, m_scnt, m_ecnt;

    task automatic model_edge(input int r, input int s, input int res,
                              input int smp, input int clr);
        int idx;
        int e;
        if (r == 0) begin
            m_pos = -1; m_last = 0; m_dice = 0; m_lamps = 0;
            m_pulse = 0; m_flag = 0; m_code = 0; m_scnt = 0; m_ecnt = 0;
            return;
        end
        e = 0;
        if (smp != 0) begin
            if (m_scnt < 255) m_scnt++;
            if (s != m_last) m_pos = -1;
            m_last = s;
            if (s == 0) begin
                if (res >= 1 && res <= 6) m_dice = res;
                else e = 1;
            end else begin
                idx = -1;
                for (int k = 0; k < 4; k++) if (int'(lc[k]) == res) idx = k;
                if (idx < 0) begin
                    e = 2;
                end else begin
                    if (m_pos >= 0 && idx != m_pos && idx != (m_pos + 1) % 4) e = 3;
                    m_pos = idx;
                    m_lamps = res;
                end
            end
        end
        m_pulse = (e != 0) ? 1 : 0;
        if (e != 0) begin
            m_flag = 1; m_code = e;
            if (m_ecnt < 255) m_ecnt++;
        end else if (clr != 0) begin
            m_flag = 0;
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int sat7(input int v);
        return (v > 7) ? 7 : v;
    endfunction

    task automatic chk_all(input string tag, input int d, input int l, input int p,
                           input int f, input int c, input int sc, input int ec);
        chk({tag, ".dice_val"},   int'(dice_val), d);
        chk({tag, ".lamps"},      int'({red, amber, green}), l);
        chk({tag, ".err_pulse"},  int'(err_pulse), p);
        chk({tag, ".err_flag"},   int'(err_flag), f);
        chk({tag, ".err_code"},   int'(err_code), c);
        chk({tag, ".sample_cnt"}, int'(sample_cnt), sc);
        chk({tag, ".err_cnt"},    int'(err_cnt), ec);
        chk({tag, ".s_sample_cnt"}, int'(s_sample_cnt), sat7(sc));
        chk({tag, ".s_err_cnt"},    int'(s_err_cnt), sat7(ec));
        chk({tag, ".s_err_flag"},   int'(s_err_flag), f);
    endtask

    // Drive one cycle: inputs after the edge, compare 1 time unit after the next edge
    task automatic step(input int r, input int s, input int res,
                        input int smp, input int clr);
        rst     = (r != 0);
        sel     = (s != 0);
        result  = 3'(res);
        sample  = (smp != 0);
        clr_err = (clr != 0);
        @(posedge clk);
        model_edge(r, s, res, smp, clr);
        #1;
    endtask

    typedef struct {
        int r, s, res, smp, clr;
        int d, l, p, f, c, sc, ec;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int r, input int s, input int res, input int smp,
                       input int clr, input int d, input int l, input int p,
                       input int f, input int c, input int sc, input int ec);
        vec_t v;
        v = '{r, s, res, smp, clr, d, l, p, f, c, sc, ec};
        tbl.push_back(v);
    endtask

    initial begin
        int rs, rr, rsmp, rclr, rrst;
        vec_t v;
        //   rst sel res smp clr | dice lamps pulse flag code scnt ecnt
        add(0, 0, 0, 0, 0,   0, 3'b000, 0, 0, 0,  0, 0);
        add(0, 0, 0, 0, 0,   0, 3'b000, 0, 0, 0,  0, 0);
        add(1, 0, 0, 0, 0,   0, 3'b000, 0, 0, 0,  0, 0);
        add(0, 0, 3, 1, 0,   0, 3'b000, 0, 0, 0,  0, 0);
        add(1, 0, 1, 0, 0,   0, 3'b000, 0, 0, 0,  0, 0);
        add(1, 0, 1, 1, 0,   1, 3'b000, 0, 0, 0,  1, 0);
        add(1, 0, 2, 1, 0,   2, 3'b000, 0, 0, 0,  2, 0);
        add(1, 0, 3, 1, 0,   3, 3'b000, 0, 0, 0,  3, 0);
        add(1, 0, 4, 1, 0,   4, 3'b000, 0, 0, 0,  4, 0);
        add(1, 0, 5, 1, 0,   5, 3'b000, 0, 0, 0,  5, 0);
        add(1, 0, 6, 1, 0,   6, 3'b000, 0, 0, 0,  6, 0);
        add(1, 0, 0, 1, 0,   6, 3'b000, 1, 1, 1,  7, 1);
        add(1, 0, 7, 1, 0,   6, 3'b000, 1, 1, 1,  8, 2);
        add(1, 0, 0, 0, 1,   6, 3'b000, 0, 0, 1,  8, 2);
        add(1, 1, 3'b100, 1, 0, 6, 3'b100, 0, 0, 1,  9, 2);
        add(1, 1, 3'b110, 1, 0, 6, 3'b110, 0, 0, 1, 10, 2);
        add(1, 1, 3'b001, 1, 0, 6, 3'b001, 0, 0, 1, 11, 2);
        add(1, 1, 3'b010, 1, 0, 6, 3'b010, 0, 0, 1, 12, 2);
        add(1, 1, 3'b100, 1, 0, 6, 3'b100, 0, 0, 1, 13, 2);
        add(1, 1, 3'b100, 1, 0, 6, 3'b100, 0, 0, 1, 14, 2);
        add(1, 1, 3'b001, 1, 0, 6, 3'b001, 1, 1, 3, 15, 3);
        add(1, 1, 3'b010, 1, 0, 6, 3'b010, 0, 1, 3, 16, 3);
        add(1, 1, 3'b100, 1, 0, 6, 3'b100, 0, 1, 3, 17, 3);
        add(1, 1, 3'b011, 1, 0, 6, 3'b100, 1, 1, 2, 18, 4);
        add(1, 1, 3'b110, 1, 0, 6, 3'b110, 0, 1, 2, 19, 4);
        add(1, 1, 3'b001, 1, 0, 6, 3'b001, 0, 1, 2, 20, 4);
        add(1, 0, 4,      1, 0, 4, 3'b001, 0, 1, 2, 21, 4);
        add(1, 1, 3'b100, 1, 0, 4, 3'b100, 0, 1, 2, 22, 4);
        add(1, 1, 3'b111, 1, 1, 4, 3'b100, 1, 1, 2, 23, 5);
        add(1, 1, 3'b000, 0, 1, 4, 3'b100, 0, 0, 2, 23, 5);
        add(1, 1, 3'b000, 0, 0, 4, 3'b100, 0, 0, 2, 23, 5);
        add(0, 1, 3'b100, 1, 0, 0, 3'b000, 0, 0, 0,  0, 0);

        @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            v = tbl[i];
            step(v.r, v.s, v.res, v.smp, v.clr);
            chk_all($sformatf("vec%0d", i), v.d, v.l, v.p, v.f, v.c, v.sc, v.ec);
        end

        // Random run; resets only in the tail so the 8-bit counter saturates first
        rs = 0;
        for (int i = 0; i < 520; i++) begin
            if ($urandom_range(0, 9) == 0) rs = 1 - rs;
            rr   = (i % 3 == 0) ? $urandom_range(0, 7)
                                : int'(lc[$urandom_range(0, 3)]);
            rsmp = ($urandom_range(0, 9) < 7) ? 1 : 0;
            rclr = ($urandom_range(0, 9) == 0) ? 1 : 0;
            rrst = (i >= 420 && $urandom_range(0, 49) == 0) ? 0 : 1;
            step(rrst, rs, rr, rsmp, rclr);
            chk_all($sformatf("rnd%0d", i), m_dice, m_lamps, m_pulse,
                    m_flag, m_code, m_scnt, m_ecnt);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
